alarm_mode_controller: RTL and testbench

//  Top-level mode FSM for the alarm clock. Sequences the display multiplexor

---
 rtl/alarm_mode_controller_pkg.sv | 19 +
 rtl/alarm_mode_controller_btn_edge.sv | 19 +
 rtl/alarm_mode_controller.sv | 210 +++++++++++++++++++++
 tb/tb_alarm_mode_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_mode_controller_pkg.sv
// Shared types and constants for the alarm clock mode controller.
// State encoding, display selector codes and entry digit count.
package alarm_mode_controller_pkg;

  typedef enum logic [2:0] {
    ST_SHOW_TIME   = 3'd0,
    ST_ENTER_TIME  = 3'd1,
    ST_ENTER_ALARM = 3'd2,
    ST_RINGING     = 3'd3,
    ST_SNOOZE      = 3'd4
  } state_t;

  localparam logic [1:0] SEL_CURRENT = 2'd0;
  localparam logic [1:0] SEL_ALARM   = 2'd1;
  localparam logic [1:0] SEL_KEYPAD  = 2'd2;

  localparam logic [2:0] DIGITS_FULL = 3'd4;

endpackage

// File: rtl/alarm_mode_controller_btn_edge.sv
// Rising-edge detector on a registered previous value.
// Ports: clk, reset_n, btn (level in), rise (high while btn=1, prev=0).
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/alarm_mode_controller.sv
// Mode FSM: display select, keypad entry, load strobes, ring/snooze.
// Ports: buttons, tick_1hz, keypad/time buses in; selector, strobes out.
module alarm_mode_controller
  import alarm_mode_controller_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 10,
  parameter int RING_TICKS    = 60,
  parameter int SNOOZE_TICKS  = 300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_1hz,
  input  logic        set_time_btn,
  input  logic        set_alarm_btn,
  input  logic        confirm_btn,
  input  logic        snooze_btn,
  input  logic        show_alarm,
  input  logic        alarm_enable,
  input  logic        shift_pulse,
  input  logic [15:0] keypad_time,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  output logic [1:0]  selector,
  output logic        reset_shift,
  output logic        load_time,
  output logic        load_alarm,
  output logic        alarm_sound,
  output logic        entry_error
);

  localparam int MAX_A =
    (TIMEOUT_TICKS > RING_TICKS) ? TIMEOUT_TICKS : RING_TICKS;
  localparam int MAX_T =
    (MAX_A > SNOOZE_TICKS) ? MAX_A : SNOOZE_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] RING_LAST =
    CNT_W'(RING_TICKS - 1);
  localparam logic [CNT_W-1:0] SNZ_LAST =
    CNT_W'(SNOOZE_TICKS - 1);

  function automatic logic bcd_valid(
    input logic [15:0] t
  );
    logic ok;
    ok = (t[15:12] <= 4'd2) &&
         (t[11:8]  <= 4'd9) &&
         (t[7:4]   <= 4'd5) &&
         (t[3:0]   <= 4'd9);
    if (t[15:12] == 4'd2 && t[11:8] > 4'd3)
      ok = 1'b0;
    return ok;
  endfunction

  logic st_rise, sa_rise, cf_rise, sn_rise;
  logic any_rise;

  btn_edge u_st (
    .clk(clk), .reset_n(reset_n),
    .btn(set_time_btn), .rise(st_rise)
  );
  btn_edge u_sa (
    .clk(clk), .reset_n(reset_n),
    .btn(set_alarm_btn), .rise(sa_rise)
  );
  btn_edge u_cf (
    .clk(clk), .reset_n(reset_n),
    .btn(confirm_btn), .rise(cf_rise)
  );
  btn_edge u_sn (
    .clk(clk), .reset_n(reset_n),
    .btn(snooze_btn), .rise(sn_rise)
  );

  assign any_rise = st_rise | sa_rise | cf_rise | sn_rise;

  state_t           state, state_n;
  logic [2:0]       digit_cnt, digit_eff;
  logic [CNT_W-1:0] tick_cnt;
  logic             match_q, match_d, ring_trig;
  logic             in_entry;

  logic [1:0] sel_n;
  logic       rs_n, lt_n, la_n, snd_n, err_n, err_set;

  // Only the rising edge of match rings, so a dismissed
  // alarm stays quiet for the rest of the matching minute.
  assign ring_trig = match_q & ~match_d;

  assign in_entry = (state == ST_ENTER_TIME) ||
                    (state == ST_ENTER_ALARM);

  // A digit arriving with confirm counts toward the entry.
  assign digit_eff =
    (shift_pulse && digit_cnt < DIGITS_FULL) ?
    digit_cnt + 3'd1 : digit_cnt;

  always_comb begin
    state_n = state;
    rs_n    = 1'b0;
    lt_n    = 1'b0;
    la_n    = 1'b0;
    err_set = 1'b0;
    unique case (state)
      ST_SHOW_TIME: begin
        if (ring_trig) begin
          state_n = ST_RINGING;
        end else if (st_rise) begin
          state_n = ST_ENTER_TIME;
          rs_n    = 1'b1;
        end else if (sa_rise) begin
          state_n = ST_ENTER_ALARM;
          rs_n    = 1'b1;
        end
      end
      ST_ENTER_TIME, ST_ENTER_ALARM: begin
        if (ring_trig) begin
          state_n = ST_RINGING;
        end else if (cf_rise) begin
          state_n = ST_SHOW_TIME;
          if (digit_eff == DIGITS_FULL &&
              bcd_valid(keypad_time)) begin
            lt_n = (state == ST_ENTER_TIME);
            la_n = (state == ST_ENTER_ALARM);
          end else begin
            err_set = 1'b1;
          end
        end else if (tick_1hz && !shift_pulse &&
                     tick_cnt == TO_LAST) begin
          state_n = ST_SHOW_TIME;
        end
      end
      ST_RINGING: begin
        if (cf_rise || !alarm_enable)
          state_n = ST_SHOW_TIME;
        else if (sn_rise)
          state_n = ST_SNOOZE;
        else if (tick_1hz && tick_cnt == RING_LAST)
          state_n = ST_SHOW_TIME;
      end
      ST_SNOOZE: begin
        if (cf_rise || !alarm_enable)
          state_n = ST_SHOW_TIME;
        else if (tick_1hz && tick_cnt == SNZ_LAST)
          state_n = ST_RINGING;
      end
      default: state_n = ST_SHOW_TIME;
    endcase

    unique case (state_n)
      ST_SHOW_TIME:
        sel_n = show_alarm ? SEL_ALARM : SEL_CURRENT;
      ST_ENTER_TIME, ST_ENTER_ALARM:
        sel_n = SEL_KEYPAD;
      default:
        sel_n = SEL_CURRENT;
    endcase

    snd_n = (state_n == ST_RINGING);

    if (err_set)       err_n = 1'b1;
    else if (any_rise) err_n = 1'b0;
    else               err_n = entry_error;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SHOW_TIME;
      selector    <= SEL_CURRENT;
      reset_shift <= 1'b0;
      load_time   <= 1'b0;
      load_alarm  <= 1'b0;
      alarm_sound <= 1'b0;
      entry_error <= 1'b0;
      match_q     <= 1'b0;
      match_d     <= 1'b0;
    end else begin
      state       <= state_n;
      selector    <= sel_n;
      reset_shift <= rs_n;
      load_time   <= lt_n;
      load_alarm  <= la_n;
      alarm_sound <= snd_n;
      entry_error <= err_n;
      match_q     <= alarm_enable &&
                     (current_time == alarm_time);
      match_d     <= match_q;
    end
  end

  // Counters restart on every state entry and saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_cnt <= 3'd0;
      tick_cnt  <= '0;
    end else if (state_n != state) begin
      digit_cnt <= 3'd0;
      tick_cnt  <= '0;
    end else begin
      digit_cnt <= digit_eff;
      if (in_entry && shift_pulse)
        tick_cnt <= '0;
      else if (tick_1hz && tick_cnt != '1)
        tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Directed bench for alarm_mode_controller with a load scoreboard.
// Expected loads are queued at stimulus time and popped on each strobe.
module tb_alarm_mode_controller;
  import alarm_mode_controller_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        set_time_btn = 1'b0;
  logic        set_alarm_btn = 1'b0;
  logic        confirm_btn = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        show_alarm = 1'b0;
  logic        alarm_enable = 1'b0;
  logic        shift_pulse = 1'b0;
  logic [15:0] keypad_time = 16'h0;
  logic [15:0] current_time = 16'h1000;
  logic [15:0] alarm_time = 16'h0700;
  logic [1:0]  selector;
  logic        reset_shift, load_time, load_alarm;
  logic        alarm_sound, entry_error;

  alarm_mode_controller dut (
    .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz),
    .set_time_btn(set_time_btn),
    .set_alarm_btn(set_alarm_btn),
    .confirm_btn(confirm_btn), .snooze_btn(snooze_btn),
    .show_alarm(show_alarm), .alarm_enable(alarm_enable),
    .shift_pulse(shift_pulse), .keypad_time(keypad_time),
    .current_time(current_time), .alarm_time(alarm_time),
    .selector(selector), .reset_shift(reset_shift),
    .load_time(load_time), .load_alarm(load_alarm),
    .alarm_sound(alarm_sound), .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_alarm;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int rs_cnt = 0;
  int lt_cnt = 0;
  int la_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, selector, reset_shift, load_time,
            load_alarm, alarm_sound, entry_error};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset_shift) rs_cnt++;
    if (load_time)   lt_cnt++;
    if (load_alarm)  la_cnt++;
    if (load_time || load_alarm) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("load_kind", {30'd0, load_time, load_alarm},
            e.is_alarm ? 32'd1 : 32'd2);
        chk("load_val", {16'd0, keypad_time}, {16'd0, e.val});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int b);
    case (b)
      0: set_time_btn = 1'b1;
      1: set_alarm_btn = 1'b1;
      2: confirm_btn = 1'b1;
      3: snooze_btn = 1'b1;
      default: ;
    endcase
    cyc(1);
    set_time_btn = 1'b0;
    set_alarm_btn = 1'b0;
    confirm_btn = 1'b0;
    snooze_btn = 1'b0;
    cyc(1);
  endtask

  task automatic digits(input int n);
    repeat (n) begin
      shift_pulse = 1'b1;
      cyc(1);
      shift_pulse = 1'b0;
      cyc(1);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      cyc(1);
      tick_1hz = 1'b0;
      cyc(1);
    end
  endtask

  task automatic start_entry(input int b, input string tag);
    int rs0;
    rs0 = rs_cnt;
    press(b);
    chk({tag, "_sel"}, {30'd0, selector}, {30'd0, SEL_KEYPAD});
    chk({tag, "_rs"}, rs_cnt, rs0 + 1);
  endtask

  task automatic wait_sound(input string tag);
    for (int i = 0; i < 4 && !alarm_sound; i++) cyc(1);
    chk(tag, {31'd0, alarm_sound}, 1);
  endtask

  logic [15:0] bad [3] = '{16'h2460, 16'h2400, 16'h12A0};

  initial begin
    cyc(2);
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_outs", outs(), 0);

    // Valid time entry
    start_entry(0, "t1");
    keypad_time = 16'h1230;
    digits(4);
    exp_q.push_back('{1'b0, 16'h1230});
    press(2);
    cyc(1);
    chk("t1_sel_after", {30'd0, selector}, 0);
    chk("t1_lt_cnt", lt_cnt, 1);
    chk("t1_err", {31'd0, entry_error}, 0);

    show_alarm = 1'b1;
    cyc(2);
    chk("show_alarm_sel", {30'd0, selector}, {30'd0, SEL_ALARM});
    show_alarm = 1'b0;
    cyc(2);

    // Invalid BCD entries
    foreach (bad[i]) begin
      start_entry(0, "bad");
      keypad_time = bad[i];
      digits(4);
      press(2);
      cyc(1);
      chk("bad_err", {31'd0, entry_error}, 1);
      chk("bad_sel", {30'd0, selector}, 0);
    end

    // Short entry
    start_entry(1, "short");
    chk("short_err_clr", {31'd0, entry_error}, 0);
    keypad_time = 16'h0645;
    digits(3);
    press(2);
    cyc(1);
    chk("short_err", {31'd0, entry_error}, 1);

    // Timeout boundary
    start_entry(0, "to");
    digits(1);
    ticks(9);
    chk("to_sel_9", {30'd0, selector}, {30'd0, SEL_KEYPAD});
    ticks(1);
    chk("to_sel_10", {30'd0, selector}, 0);
    chk("to_err", {31'd0, entry_error}, 0);

    // Fourth digit arrives with confirm
    start_entry(1, "al");
    keypad_time = 16'h2359;
    digits(3);
    exp_q.push_back('{1'b1, 16'h2359});
    shift_pulse = 1'b1;
    confirm_btn = 1'b1;
    cyc(1);
    shift_pulse = 1'b0;
    confirm_btn = 1'b0;
    cyc(2);
    chk("al_la_cnt", la_cnt, 1);
    chk("al_err", {31'd0, entry_error}, 0);

    // Ring, snooze, dismiss
    alarm_enable = 1'b1;
    current_time = 16'h0700;
    wait_sound("ring_rise");
    press(3);
    chk("snooze_quiet", {31'd0, alarm_sound}, 0);
    ticks(299);
    chk("snooze_299", {31'd0, alarm_sound}, 0);
    ticks(1);
    chk("snooze_300", {31'd0, alarm_sound}, 1);
    press(2);
    chk("dismiss", {31'd0, alarm_sound}, 0);
    cyc(10);
    chk("no_retrig", {31'd0, alarm_sound}, 0);

    // Match during alarm entry, then auto-dismiss
    current_time = 16'h0701;
    cyc(3);
    start_entry(1, "ea");
    digits(2);
    current_time = 16'h0700;
    wait_sound("ea_ring");
    chk("ea_sel", {30'd0, selector}, 0);
    chk("ea_err", {31'd0, entry_error}, 0);
    ticks(59);
    chk("ring_59", {31'd0, alarm_sound}, 1);
    ticks(1);
    chk("ring_60", {31'd0, alarm_sound}, 0);

    // Disable while ringing
    current_time = 16'h0701;
    cyc(2);
    current_time = 16'h0700;
    wait_sound("en_ring");
    alarm_enable = 1'b0;
    cyc(2);
    chk("en_off", {31'd0, alarm_sound}, 0);

    // Async reset mid-ring
    alarm_enable = 1'b1;
    current_time = 16'h0701;
    cyc(2);
    current_time = 16'h0700;
    wait_sound("rst_ring");
    #2 reset_n = 1'b0;
    #1 chk("rst_ring_outs", outs(), 0);
    alarm_enable = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // Async reset mid-entry
    start_entry(0, "rst_e");
    #2 reset_n = 1'b0;
    #1 chk("rst_entry_outs", outs(), 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // Simultaneous set_time and set_alarm
    set_time_btn = 1'b1;
    set_alarm_btn = 1'b1;
    cyc(1);
    set_time_btn = 1'b0;
    set_alarm_btn = 1'b0;
    cyc(1);
    chk("both_sel", {30'd0, selector}, {30'd0, SEL_KEYPAD});
    keypad_time = 16'h0815;
    digits(4);
    exp_q.push_back('{1'b0, 16'h0815});
    press(2);
    cyc(1);

    chk("sb_drained", exp_q.size(), 0);
    chk("lt_total", lt_cnt, 2);
    chk("la_total", la_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
